// File: rtl/max_scan_ctrl_if.sv
// Handshake and result signals shared between the scan controller and its client.
interface max_scan_ctrl_if;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       busy;
  logic [3:0] max_val;
  logic [3:0] max_idx;
  logic       done;

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, max_val, max_idx, done
  );

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, max_val, max_idx, done
  );
endinterface

// File: rtl/max_scan_ctrl.sv
// Streams a fixed-length scan of 4-bit samples and reports the maximum value
// and its earliest position, with a one-cycle done pulse.
module max_scan_ctrl (
  input  logic           clk,
  input  logic           reset,
  max_scan_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_len;
  logic [3:0] r_cnt;
  logic [3:0] r_max_val;
  logic [3:0] r_max_idx;

  logic w_in_ready;
  logic w_xfer;
  logic w_gt;
  logic w_last;

  assign w_in_ready = (r_state == S_ACCEPT);
  assign w_xfer     = bus.in_valid & w_in_ready;
  // Single strict comparator: ties never replace the stored maximum.
  assign w_gt       = (bus.in_data > r_max_val);
  assign w_last     = (r_cnt == (r_len - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.len != 4'd0) begin
              r_len   <= bus.len;
              r_cnt   <= '0;
              r_state <= S_ACCEPT;
            end else begin
              r_max_val <= '0;
              r_max_idx <= '0;
              r_state   <= S_DONE;
            end
          end
        end
        S_ACCEPT: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 4'd1;
            if ((r_cnt == 4'd0) || w_gt) begin
              r_max_val <= bus.in_data;
              r_max_idx <= r_cnt;
            end
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = (r_state == S_ACCEPT) || (r_state == S_DONE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.max_val  = r_max_val;
  assign bus.max_idx  = r_max_idx;
endmodule
